// File: rtl/mdu_control_unit.sv
// Control FSM for a multi-cycle multiply/divide unit: decodes M-extension instructions,
// sequences start/wait/writeback, and handles flush, timeout and illegal encodings.
module mdu_control_unit #(
  parameter int DATA_SIZE = 64,
  parameter int ENABLE_M  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  input  logic       flush,
  input  logic       mdu_done,
  output logic       mdu_start,
  output logic [2:0] mdu_op,
  output logic       mdu_word,
  output logic       mdu_abort,
  output logic       stall,
  output logic       wb_en,
  output logic [4:0] wb_rd,
  output logic       illegal_instruction,
  output logic       timeout_error
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          word_q, word_d;
  logic [4:0]    rd_q, rd_d;

  logic is_r, is_rw, m_shaped, m_illegal, req, accept;
  logic start_c, abort_c, stall_c, wb_en_c, to_c;

  always_comb begin
    is_r      = (opcode == 7'b0110011);
    is_rw     = (opcode == 7'b0111011);
    m_shaped  = (is_r || is_rw) && (funct7 == 7'b0000001);
    m_illegal = m_shaped && ((ENABLE_M == 0) ||
                (is_rw && ((DATA_SIZE == 32) ||
                           (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011))));
    req    = reset && (state_q == S_IDLE) && id_valid && !flush;
    accept = req && m_shaped && !m_illegal;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    rd_d    = rd_q;
    start_c = 1'b0;
    abort_c = 1'b0;
    stall_c = 1'b0;
    wb_en_c = 1'b0;
    to_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = funct3;
          word_d  = opcode[3];
          rd_d    = rd;
          stall_c = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        start_c = 1'b1;
        stall_c = 1'b1;
        cnt_d   = '0;
        if (flush) begin
          abort_c = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        // Priority: flush beats done, done beats timeout.
        if (flush) begin
          abort_c = 1'b1;
          state_d = S_IDLE;
        end else if (mdu_done) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_MAX) begin
          abort_c = 1'b1;
          to_c    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        wb_en_c = (rd_q != 5'd0) && !flush;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
    end
  end

  // State-decoded outputs are masked while reset is low so an abandoned
  // operation never produces an abort, timeout or writeback.
  assign mdu_start           = reset && start_c;
  assign mdu_abort           = reset && abort_c;
  assign stall               = reset && stall_c;
  assign wb_en               = reset && wb_en_c;
  assign timeout_error       = reset && to_c;
  assign illegal_instruction = req && m_illegal;
  assign mdu_op              = op_q;
  assign mdu_word            = word_q;
  assign wb_rd               = rd_q;

endmodule

// File: tb/tb_mdu_control_unit.sv
// Directed bench for mdu_control_unit: decode table plus hand-written FSM sequences
// on three instances (default, DATA_SIZE=32/TIMEOUT=4, ENABLE_M=0).
module tb_mdu_control_unit;

  logic       clock = 1'b0;
  logic       reset, id_valid, flush, mdu_done;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;

  logic       a_start, a_word, a_abort, a_stall, a_wb_en, a_ill, a_to;
  logic [2:0] a_op;
  logic [4:0] a_wb_rd;
  logic       b_start, b_word, b_abort, b_stall, b_wb_en, b_ill, b_to;
  logic [2:0] b_op;
  logic [4:0] b_wb_rd;
  logic       c_start, c_word, c_abort, c_stall, c_wb_en, c_ill, c_to;
  logic [2:0] c_op;
  logic [4:0] c_wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mdu_control_unit dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .flush(flush), .mdu_done(mdu_done),
    .mdu_start(a_start), .mdu_op(a_op), .mdu_word(a_word), .mdu_abort(a_abort),
    .stall(a_stall), .wb_en(a_wb_en), .wb_rd(a_wb_rd),
    .illegal_instruction(a_ill), .timeout_error(a_to));

  mdu_control_unit #(.DATA_SIZE(32), .TIMEOUT(4)) d32 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .flush(flush), .mdu_done(mdu_done),
    .mdu_start(b_start), .mdu_op(b_op), .mdu_word(b_word), .mdu_abort(b_abort),
    .stall(b_stall), .wb_en(b_wb_en), .wb_rd(b_wb_rd),
    .illegal_instruction(b_ill), .timeout_error(b_to));

  mdu_control_unit #(.ENABLE_M(0)) dnm (
    .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rd(rd), .flush(flush), .mdu_done(mdu_done),
    .mdu_start(c_start), .mdu_op(c_op), .mdu_word(c_word), .mdu_abort(c_abort),
    .stall(c_stall), .wb_en(c_wb_en), .wb_rd(c_wb_rd),
    .illegal_instruction(c_ill), .timeout_error(c_to));

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       fl;
    logic       ill_a, ill_b, ill_c;
    logic       acc_a, acc_b;
  } vec_t;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] RW = 7'b0111011;
  localparam logic [6:0] M7 = 7'b0000001;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r);
    id_valid = 1'b1;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rd       = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    //            op  f3      f7          rd     fl  ia   ib   ic   aa   ab
    vt[0]  = '{R,  3'b000, M7,          5'd5,  0, 0,   0,   1,   1,   1};
    vt[1]  = '{RW, 3'b100, M7,          5'd3,  0, 0,   1,   1,   1,   0};
    vt[2]  = '{RW, 3'b111, M7,          5'd12, 0, 0,   1,   1,   1,   0};
    vt[3]  = '{RW, 3'b001, M7,          5'd1,  0, 1,   1,   1,   0,   0};
    vt[4]  = '{RW, 3'b010, M7,          5'd1,  0, 1,   1,   1,   0,   0};
    vt[5]  = '{RW, 3'b011, M7,          5'd1,  0, 1,   1,   1,   0,   0};
    vt[6]  = '{R,  3'b000, 7'b0000000,  5'd1,  0, 0,   0,   0,   0,   0};
    vt[7]  = '{R,  3'b011, M7,          5'd31, 0, 0,   0,   1,   1,   1};
    vt[8]  = '{R,  3'b110, M7,          5'd7,  1, 0,   0,   0,   0,   0};
    vt[9]  = '{RW, 3'b001, M7,          5'd2,  1, 0,   0,   0,   0,   0};
    vt[10] = '{7'b0010011, 3'b000, M7,  5'd4,  0, 0,   0,   0,   0,   0};
    vt[11] = '{R,  3'b101, M7,          5'd17, 0, 0,   0,   1,   1,   1};
    vt[12] = '{RW, 3'b000, M7,          5'd9,  0, 0,   1,   1,   1,   0};
    vt[13] = '{RW, 3'b000, 7'b0100000,  5'd0,  0, 0,   0,   0,   0,   0};

    reset = 1'b0; id_valid = 1'b0; flush = 1'b0; mdu_done = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0;

    // Reset state, and combinational outputs masked during reset
    tick(); tick();
    chk("rst_stall", a_stall, 0);
    chk("rst_start", a_start, 0);
    chk("rst_op", a_op, 0);
    chk("rst_wb_rd", a_wb_rd, 0);
    chk("rst_wb_en", a_wb_en, 0);
    chk("rst_abort", a_abort, 0);
    chk("rst_to", a_to, 0);
    drive(R, 3'b000, M7, 5'd5); #1;
    chk("rst_stall_masked", a_stall, 0);
    drive(RW, 3'b001, M7, 5'd5); #1;
    chk("rst_ill_masked", a_ill, 0);
    id_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Decode table
    for (int unsigned i = 0; i < 14; i++) begin
      drive(vt[i].op, vt[i].f3, vt[i].f7, vt[i].rd);
      flush = vt[i].fl;
      #1;
      chk($sformatf("v%0d_ill_a", i), a_ill, vt[i].ill_a);
      chk($sformatf("v%0d_ill_b", i), b_ill, vt[i].ill_b);
      chk($sformatf("v%0d_ill_c", i), c_ill, vt[i].ill_c);
      chk($sformatf("v%0d_stall_a", i), a_stall, vt[i].acc_a);
      chk($sformatf("v%0d_stall_b", i), b_stall, vt[i].acc_b);
      chk($sformatf("v%0d_stall_c", i), c_stall, 0);
      tick();
      id_valid = 1'b0; flush = 1'b0;
      #1;
      chk($sformatf("v%0d_start_a", i), a_start, vt[i].acc_a);
      chk($sformatf("v%0d_start_b", i), b_start, vt[i].acc_b);
      chk($sformatf("v%0d_start_c", i), c_start, 0);
      if (vt[i].acc_a) begin
        chk($sformatf("v%0d_op", i), a_op, vt[i].f3);
        chk($sformatf("v%0d_word", i), a_word, (vt[i].op == RW));
        chk($sformatf("v%0d_wb_rd", i), a_wb_rd, vt[i].rd);
      end
      flush = 1'b1;
      #1;
      chk($sformatf("v%0d_abort", i), a_abort, vt[i].acc_a);
      tick();
      flush = 1'b0;
      #1;
      chk($sformatf("v%0d_idle", i), a_stall, 0);
    end

    // MUL x5, done three cycles after start; WB blocks a new acceptance
    drive(R, 3'b000, M7, 5'd5); #1;
    stall_cnt = a_stall;
    tick(); id_valid = 1'b0; #1;
    chk("mul_start", a_start, 1);
    stall_cnt += a_stall;
    tick(); stall_cnt += a_stall;
    chk("mul_start_once", a_start, 0);
    tick(); stall_cnt += a_stall;
    tick(); mdu_done = 1'b1; #1; stall_cnt += a_stall;
    tick(); mdu_done = 1'b0; drive(R, 3'b000, M7, 5'd7); #1;
    chk("mul_stall_cycles", stall_cnt, 5);
    chk("mul_wb_stall", a_stall, 0);
    chk("mul_wb_en", a_wb_en, 1);
    chk("mul_wb_rd", a_wb_rd, 5);
    chk("mul_op", a_op, 0);
    chk("mul_word", a_word, 0);
    tick();
    chk("b2b_wb_en_once", a_wb_en, 0);
    chk("b2b_no_start", a_start, 0);
    chk("b2b_accept", a_stall, 1);
    tick(); id_valid = 1'b0; #1;
    chk("b2b_start", a_start, 1);
    chk("b2b_wb_rd", a_wb_rd, 7);
    flush = 1'b1; tick(); flush = 1'b0; #1;

    // Flush together with done on the second Wait cycle
    drive(R, 3'b000, M7, 5'd9); #1;
    tick(); id_valid = 1'b0;
    tick();
    tick(); flush = 1'b1; mdu_done = 1'b1; #1;
    chk("fd_abort", a_abort, 1);
    chk("fd_wb_en", a_wb_en, 0);
    tick(); flush = 1'b0; mdu_done = 1'b0; #1;
    chk("fd_idle_stall", a_stall, 0);
    chk("fd_abort_once", a_abort, 0);
    chk("fd_no_wb", a_wb_en, 0);
    drive(R, 3'b000, M7, 5'd10); #1;
    chk("fd_idle_accept", a_stall, 1);

    // Flush during Writeback suppresses the write
    tick(); id_valid = 1'b0;
    tick(); mdu_done = 1'b1;
    tick(); mdu_done = 1'b0; flush = 1'b1; #1;
    chk("wbfl_wb_en", a_wb_en, 0);
    tick(); flush = 1'b0; #1;
    chk("wbfl_idle_wb", a_wb_en, 0);
    chk("wbfl_idle_stall", a_stall, 0);

    // rd=0 MULHU completes without a write
    drive(R, 3'b011, M7, 5'd0); #1;
    tick(); id_valid = 1'b0;
    tick(); mdu_done = 1'b1;
    tick(); mdu_done = 1'b0; #1;
    chk("rd0_wb_en", a_wb_en, 0);
    chk("rd0_stall", a_stall, 0);
    chk("rd0_op", a_op, 3'b011);
    tick();

    // Reset during Wait
    drive(RW, 3'b111, M7, 5'd6); #1;
    tick(); id_valid = 1'b0; #1;
    chk("remuw_op", a_op, 3'b111);
    chk("remuw_word", a_word, 1);
    tick(); reset = 1'b0; #1;
    chk("rstw_abort", a_abort, 0);
    chk("rstw_stall", a_stall, 0);
    tick();
    chk("rstw_op", a_op, 0);
    chk("rstw_word", a_word, 0);
    chk("rstw_wb_rd", a_wb_rd, 0);
    chk("rstw_start", a_start, 0);
    chk("rstw_wb_en", a_wb_en, 0);
    reset = 1'b1;
    tick();
    chk("rstw_after_wb", a_wb_en, 0);
    chk("rstw_after_stall", a_stall, 0);

    // Timeout on the TIMEOUT=4 instance: pulse on the fifth cycle after Start
    drive(R, 3'b000, M7, 5'd4); #1;
    tick(); id_valid = 1'b0; #1;
    chk("to_start", b_start, 1);
    for (int unsigned k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("to_c%0d_err", k), b_to, (k == 5));
      chk($sformatf("to_c%0d_abort", k), b_abort, (k == 5));
      chk($sformatf("to_c%0d_stall", k), b_stall, 1);
    end
    chk("to_long_no_err", a_to, 0);
    tick();
    chk("to_released", b_stall, 0);
    chk("to_err_once", b_to, 0);
    chk("to_no_wb", b_wb_en, 0);
    chk("to_long_waiting", a_stall, 1);
    flush = 1'b1; #1;
    chk("long_flush_abort", a_abort, 1);
    tick(); flush = 1'b0;
    mdu_done = 1'b1; #1;
    chk("idle_done_stall", a_stall, 0);
    tick(); mdu_done = 1'b0; #1;
    chk("idle_done_ignored_a", a_wb_en, 0);
    chk("idle_done_ignored_b", b_wb_en, 0);

    // Done on the timeout cycle wins over timeout
    drive(R, 3'b000, M7, 5'd8); #1;
    tick(); id_valid = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        mdu_done = 1'b1; #1;
        chk("tie_no_err", b_to, 0);
        chk("tie_no_abort", b_abort, 0);
      end
    end
    tick(); mdu_done = 1'b0; #1;
    chk("tie_wb_en", b_wb_en, 1);
    chk("tie_wb_rd", b_wb_rd, 8);
    chk("tie_long_wb_en", a_wb_en, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_control_unit.md
MDU_CONTROL_UNIT -- requirements
Module: mdu_control_unit

Interface
REQ-001 The module SHALL be clocked by a single clock and SHALL use a synchronous, active-low reset.
REQ-002 Parameter DATA_SIZE, default 64, SHALL set the datapath width; legal values are 32 and 64.
REQ-003 Parameter ENABLE_M, default 1, SHALL enable the M extension; when 0, every M-shaped instruction is illegal.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum number of Wait cycles before abort.
REQ-005 Port: clock  in  1  system clock.
REQ-006 Port: reset  in  1  synchronous, active-low reset.
REQ-007 Port: id_valid  in  1  decode-stage instruction valid.
REQ-008 Port: opcode  in  7  instruction opcode.
REQ-009 Port: funct3  in  3  instruction funct3.
REQ-010 Port: funct7  in  7  instruction funct7.
REQ-011 Port: rd  in  5  destination register.
REQ-012 Port: flush  in  1  pipeline flush (exception, mret or sret).
REQ-013 Port: mdu_done  in  1  MDU result ready.
REQ-014 Port: mdu_start  out  1  single-cycle MDU start pulse.
REQ-015 Port: mdu_op  out  3  latched funct3.
REQ-016 Port: mdu_word  out  1  latched W-variant flag.
REQ-017 Port: mdu_abort  out  1  single-cycle MDU cancel pulse.
REQ-018 Port: stall  out  1  holds the fetch and decode stages.
REQ-019 Port: wb_en  out  1  register-file write enable for the MDU result.
REQ-020 Port: wb_rd  out  5  latched destination register.
REQ-021 Port: illegal_instruction  out  1  illegal M-shaped instruction.
REQ-022 Port: timeout_error  out  1  single-cycle timeout pulse.

Function
REQ-023 An instruction SHALL be M-shaped when opcode is 0110011 (R) or 0111011 (RW) and funct7 is 0000001.
REQ-024 An M-shaped instruction SHALL be illegal when any of the following holds: ENABLE_M is 0; it is RW and DATA_SIZE is 32; or it is RW and funct3 is 001, 010 or 011.
REQ-025 illegal_instruction SHALL be driven combinationally: 1 only in Idle, with id_valid high, flush low, and an illegal M-shaped instruction; an illegal instruction SHALL NOT start the FSM.
REQ-026 The FSM SHALL have four states: Idle, Start, Wait and Writeback.
REQ-027 Idle: on id_valid & legal M-shaped & !flush, latch funct3 to mdu_op, opcode[3] to mdu_word and rd to wb_rd, assert stall combinationally in the same cycle, and go to Start.
REQ-028 Start: mdu_start=1 and stall=1 for exactly one cycle; the cycle counter SHALL be cleared; next state is Wait.
REQ-029 Wait: stall=1; the counter SHALL increment by 1 per cycle; on mdu_done go to Writeback; when the counter equals TIMEOUT without mdu_done, pulse timeout_error and mdu_abort, discard the result and go to Idle.
REQ-030 mdu_done SHALL be ignored outside Wait.
REQ-031 Writeback: stall=0; wb_en=(wb_rd!=0) for one cycle; next state is Idle.
REQ-032 Flush in Start or Wait: pulse mdu_abort, no writeback, go to Idle next cycle.
REQ-033 Flush in Writeback: force wb_en=0 and go to Idle.
REQ-034 Flush in Idle: block acceptance.
REQ-035 When flush and mdu_done are high in the same cycle, flush SHALL win.
REQ-036 When Wait reaches TIMEOUT and mdu_done is high in the same cycle, mdu_done SHALL win.
REQ-037 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL NOT wrap.
REQ-038 Back-to-back M instructions SHALL be accepted only from Idle, giving a minimum spacing of 4 cycles from acceptance to the next acceptance.
REQ-039 mdu_op, mdu_word and wb_rd SHALL hold their latched values from Start until the FSM returns to Idle.

Reset
REQ-040 While reset=0 at a clock edge, the FSM SHALL enter Idle, the counter and latches SHALL be cleared, and every registered output SHALL be 0.
REQ-041 While reset is held low, stall and illegal_instruction SHALL be 0.
REQ-042 A reset asserted mid-operation SHALL abandon the operation without pulsing mdu_abort and without any writeback.

Verification
REQ-043 MUL x5 (opcode 0110011, funct7 01, funct3 000, rd 5), mdu_done three cycles after mdu_start -> stall high for 5 cycles, then wb_en=1 with wb_rd=5, mdu_op=000, mdu_word=0.
REQ-044 DIVW with DATA_SIZE=32 -> illegal_instruction=1, mdu_start never asserted, stall=0.
REQ-045 REMUW (0111011, funct3 111) with DATA_SIZE=64 -> mdu_word=1, mdu_op=111; MULHW (funct3 001) -> illegal_instruction=1.
REQ-046 flush asserted on the second Wait cycle, together with mdu_done -> mdu_abort pulse, wb_en stays 0, Idle next cycle.
REQ-047 TIMEOUT=4, mdu_done never asserted -> timeout_error and mdu_abort pulse on the fifth cycle after Start, stall released, no writeback.
REQ-048 rd=0 MULHU completes -> wb_en=0 in Writeback; reset low during Wait -> all outputs 0 on the next cycle.
